onchip_sram_dp_pipe: RTL and testbench

Parametrised true-dual-port on-chip SRAM with two independent Avalon-MM slave ports, pipelined reads with `readdatavalid`, and byte-merged collision handling. It can also clear its contents to zero after reset. It sits behind the system interconnect as shared scratch/boot memory, with one port on the CPU data master and one on a DMA or second master. Each port has its own `waitrequest`.

---
 rtl/onchip_sram_pkg.sv | 13 +
 rtl/sram_tdp_core.sv | 30 +++
 rtl/onchip_sram_dp_pipe.sv | 119 +++++++++++
 tb/tb_onchip_sram_dp_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_sram_pkg.sv
// onchip_sram_pkg: shared state type, byte-merge helper and configuration check for the dual-port SRAM
package onchip_sram_pkg;
  typedef enum logic {CLEAR, READY} sram_state_t;
  localparam int MAX_W = 512;
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w, input logic [MAX_W-1:0] new_w, input logic [MAX_W/8-1:0] be);
    byte_merge = old_w;
    for (int i = 0; i < MAX_W/8; i++)
      if (be[i]) byte_merge[i*8 +: 8] = new_w[i*8 +: 8];
  endfunction
  function automatic bit cfg_ok(input int data_w, input int read_latency);
    return data_w > 0 && data_w % 8 == 0 && data_w <= MAX_W && (read_latency == 1 || read_latency == 2);
  endfunction
endpackage

// File: rtl/sram_tdp_core.sv
// sram_tdp_core: inferable true-dual-port RAM with byte enables and registered read address
module sram_tdp_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic                clk,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] a_addr_q, b_addr_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W/8; i++) begin
      if (a_we && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
      if (b_we && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
    end
    a_addr_q <= a_addr;
    b_addr_q <= b_addr;
  end
  assign a_rdata = mem[a_addr_q];
  assign b_rdata = mem[b_addr_q];
endmodule

// File: rtl/onchip_sram_dp_pipe.sv
// onchip_sram_dp_pipe: dual-port Avalon-MM SRAM with clear-after-reset, collision merge/forwarding
// and pipelined read returns
module onchip_sram_dp_pipe
  import onchip_sram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 14,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                a_chipselect,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_byteenable,
  input  logic [DATA_W-1:0]   a_writedata,
  output logic                a_waitrequest,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
  input  logic                b_chipselect,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic [DATA_W-1:0]   b_writedata,
  output logic                b_waitrequest,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid
);
  localparam int NB = DATA_W/8;
  localparam bit L2 = READ_LATENCY == 2;
  if (!cfg_ok(DATA_W, READ_LATENCY)) begin : g_bad
    $error("onchip_sram_dp_pipe: DATA_W must be a multiple of 8 and READ_LATENCY 1 or 2");
  end
  sram_state_t state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic live, clearing, busy, same, ww;
  logic [1:0] cs, rd, wr, acc, wr_acc, rd_acc, rv;
  logic [1:0][DATA_W-1:0] wd, core_rd, rdo;
  logic [1:0][NB-1:0] be;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
    else state <= state_nx;
  always_comb state_nx = (state == CLEAR && cnt == '1) ? READY : state;
  always_comb begin
    clearing = state == CLEAR;
    busy = clearing || !live;
  end
  // live keeps waitrequest high until the first edge after reset release
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      live <= 1'b0;
    end else begin
      if (clearing) cnt <= cnt + ADDR_W'(1);
      live <= 1'b1;
    end
  assign cs = {b_chipselect, a_chipselect};
  assign rd = {b_read, a_read};
  assign wr = {b_write, a_write};
  assign wd = {b_writedata, a_writedata};
  assign be = {b_byteenable, a_byteenable};
  assign acc = cs & (rd | wr) & {2{!busy}};
  assign wr_acc = acc & wr;
  assign rd_acc = acc & rd & ~wr;
  assign same = a_address == b_address;
  assign ww = wr_acc[0] & wr_acc[1] & same;
  // on a same-address double write B only keeps the lanes A left alone
  sram_tdp_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
    .clk     (clk),
    .a_we    (clearing | wr_acc[0]),
    .a_be    (clearing ? {NB{1'b1}} : a_byteenable),
    .a_addr  (clearing ? cnt : a_address),
    .a_wdata (clearing ? '0 : a_writedata),
    .a_rdata (core_rd[0]),
    .b_we    (wr_acc[1]),
    .b_be    (ww ? b_byteenable & ~a_byteenable : b_byteenable),
    .b_addr  (b_address),
    .b_wdata (b_writedata),
    .b_rdata (core_rd[1])
  );
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic v1, col1, v2, vo;
    logic [DATA_W-1:0] fwd1, d1, d2, rdq;
    logic [NB-1:0] fbe1;
    // the other port's write is replayed over the RAM output so collisions never depend on the primitive
    assign d1 = DATA_W'(byte_merge(MAX_W'(core_rd[p]), MAX_W'(fwd1), (MAX_W/8)'(col1 ? fbe1 : '0)));
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        v1 <= 1'b0;
        col1 <= 1'b0;
        fwd1 <= '0;
        fbe1 <= '0;
        v2 <= 1'b0;
        d2 <= '0;
        vo <= 1'b0;
        rdq <= '0;
      end else begin
        v1 <= rd_acc[p];
        col1 <= rd_acc[p] & wr_acc[1-p] & same;
        fwd1 <= wd[1-p];
        fbe1 <= be[1-p];
        v2 <= v1;
        d2 <= d1;
        vo <= L2 ? v2 : v1;
        if (L2 ? v2 : v1) rdq <= L2 ? d2 : d1;
      end
    assign rv[p] = vo;
    assign rdo[p] = rdq;
  end
  assign a_waitrequest = busy;
  assign b_waitrequest = busy;
  assign a_readdatavalid = rv[0];
  assign b_readdatavalid = rv[1];
  assign a_readdata = rdo[0];
  assign b_readdata = rdo[1];
endmodule

// File: tb/tb_onchip_sram_dp_pipe.sv
// tb_onchip_sram_dp_pipe: directed bench driving a latency-1 and a latency-2 instance with shared stimulus
module tb_onchip_sram_dp_pipe;
  logic clk = 1'b0;
  logic reset_n;
  logic a_chipselect, a_read, a_write, b_chipselect, b_read, b_write;
  logic [3:0] a_address, b_address, a_byteenable, b_byteenable;
  logic [31:0] a_writedata, b_writedata;
  logic u1_a_wait, u1_b_wait, u1_a_valid, u1_b_valid, u2_a_wait, u2_b_wait, u2_a_valid, u2_b_valid;
  logic [31:0] u1_a_data, u1_b_data, u2_a_data, u2_b_data;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  onchip_sram_dp_pipe #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write), .a_address(a_address),
    .a_byteenable(a_byteenable), .a_writedata(a_writedata), .a_waitrequest(u1_a_wait),
    .a_readdata(u1_a_data), .a_readdatavalid(u1_a_valid),
    .b_chipselect(b_chipselect), .b_read(b_read), .b_write(b_write), .b_address(b_address),
    .b_byteenable(b_byteenable), .b_writedata(b_writedata), .b_waitrequest(u1_b_wait),
    .b_readdata(u1_b_data), .b_readdatavalid(u1_b_valid)
  );
  onchip_sram_dp_pipe #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .reset_n(reset_n),
    .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write), .a_address(a_address),
    .a_byteenable(a_byteenable), .a_writedata(a_writedata), .a_waitrequest(u2_a_wait),
    .a_readdata(u2_a_data), .a_readdatavalid(u2_a_valid),
    .b_chipselect(b_chipselect), .b_read(b_read), .b_write(b_write), .b_address(b_address),
    .b_byteenable(b_byteenable), .b_writedata(b_writedata), .b_waitrequest(u2_b_wait),
    .b_readdata(u2_b_data), .b_readdatavalid(u2_b_valid)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    a_chipselect = 0; a_read = 0; a_write = 0; a_address = 0; a_byteenable = 0; a_writedata = 0;
    b_chipselect = 0; b_read = 0; b_write = 0; b_address = 0; b_byteenable = 0; b_writedata = 0;
  endtask
  task automatic drive_a(input logic r, input logic w, input logic [3:0] ad, input logic [3:0] en, input logic [31:0] d);
    a_chipselect = 1; a_read = r; a_write = w; a_address = ad; a_byteenable = en; a_writedata = d;
  endtask
  task automatic drive_b(input logic r, input logic w, input logic [3:0] ad, input logic [3:0] en, input logic [31:0] d);
    b_chipselect = 1; b_read = r; b_write = w; b_address = ad; b_byteenable = en; b_writedata = d;
  endtask
  task automatic test_reset();
    idle();
    reset_n = 0;
    tick();
    n_checks++;
    if ({u1_a_wait, u1_b_wait, u2_a_wait, u2_b_wait} !== 4'hf) begin
      n_fail++; $display("FAIL reset_wait got %b exp 1111", {u1_a_wait, u1_b_wait, u2_a_wait, u2_b_wait});
    end
    n_checks++;
    if ({u1_a_valid, u1_b_valid, u2_a_valid, u2_b_valid} !== 4'h0) begin
      n_fail++; $display("FAIL reset_valid got %b exp 0000", {u1_a_valid, u1_b_valid, u2_a_valid, u2_b_valid});
    end
    n_checks++;
    if ({u1_a_data, u1_b_data, u2_a_data, u2_b_data} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data got %h %h %h %h exp 0", u1_a_data, u1_b_data, u2_a_data, u2_b_data);
    end
    reset_n = 1;
    drive_a(0, 1, 4'd0, 4'hf, 32'hFFFF_FFFF);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 16) idle();
      n_checks++;
      if ({u1_a_wait, u1_b_wait, u2_a_wait, u2_b_wait} !== {4{k < 16}}) begin
        n_fail++; $display("FAIL clear_wait cycle %0d got %b exp %b", k, {u1_a_wait, u1_b_wait, u2_a_wait, u2_b_wait}, {4{k < 16}});
      end
    end
  endtask
  task automatic test_clear_contents();
    for (int ad = 0; ad < 16; ad++) begin
      drive_a(1, 0, 4'(ad), 4'hf, 32'h0);
      drive_b(1, 0, 4'(15 - ad), 4'hf, 32'h0);
      tick();
      idle();
      tick();
      n_checks++;
      if ({u1_a_valid, u1_b_valid, u1_a_data, u1_b_data} !== {2'b11, 64'h0}) begin
        n_fail++; $display("FAIL clear_read_l1 addr %0d got %b%b %h %h exp 11 0 0", ad, u1_a_valid, u1_b_valid, u1_a_data, u1_b_data);
      end
      tick();
      n_checks++;
      if ({u1_a_valid, u1_b_valid, u2_a_valid, u2_b_valid, u2_a_data, u2_b_data} !== {4'b0011, 64'h0}) begin
        n_fail++; $display("FAIL clear_read_l2 addr %0d got %b%b%b%b %h %h exp 0011 0 0", ad, u1_a_valid, u1_b_valid, u2_a_valid, u2_b_valid, u2_a_data, u2_b_data);
      end
    end
  endtask
  task automatic test_write_collision();
    drive_a(0, 1, 4'd5, 4'hf, 32'hDEAD_BEEF);
    drive_b(0, 1, 4'd5, 4'h3, 32'h1122_3344);
    tick();
    drive_a(0, 1, 4'd6, 4'hc, 32'hA1A2_A3A4);
    drive_b(0, 1, 4'd6, 4'h6, 32'hB1B2_B3B4);
    tick();
    drive_a(1, 0, 4'd5, 4'hf, 32'h0);
    drive_b(1, 0, 4'd6, 4'hf, 32'h0);
    tick();
    idle();
    tick();
    n_checks++;
    if ({u1_a_valid, u1_b_valid, u1_a_data, u1_b_data} !== {2'b11, 32'hDEAD_BEEF, 32'hA1A2_B300}) begin
      n_fail++; $display("FAIL ww_merge_l1 got %b%b %h %h exp 11 deadbeef a1a2b300", u1_a_valid, u1_b_valid, u1_a_data, u1_b_data);
    end
    tick();
    n_checks++;
    if ({u2_a_valid, u2_b_valid, u2_a_data, u2_b_data} !== {2'b11, 32'hDEAD_BEEF, 32'hA1A2_B300}) begin
      n_fail++; $display("FAIL ww_merge_l2 got %b%b %h %h exp 11 deadbeef a1a2b300", u2_a_valid, u2_b_valid, u2_a_data, u2_b_data);
    end
  endtask
  task automatic test_read_write_collision();
    drive_a(0, 1, 4'd7, 4'hc, 32'hAABB_CCDD);
    drive_b(1, 0, 4'd7, 4'hf, 32'h0);
    tick();
    idle();
    tick();
    n_checks++;
    if ({u1_a_valid, u1_b_valid, u2_b_valid, u1_b_data} !== {3'b010, 32'hAABB_0000}) begin
      n_fail++; $display("FAIL rw_fwd_b_l1 got %b%b%b %h exp 010 aabb0000", u1_a_valid, u1_b_valid, u2_b_valid, u1_b_data);
    end
    tick();
    n_checks++;
    if ({u1_b_valid, u2_a_valid, u2_b_valid, u2_b_data} !== {3'b001, 32'hAABB_0000}) begin
      n_fail++; $display("FAIL rw_fwd_b_l2 got %b%b%b %h exp 001 aabb0000", u1_b_valid, u2_a_valid, u2_b_valid, u2_b_data);
    end
    drive_a(1, 0, 4'd8, 4'hf, 32'h0);
    drive_b(0, 1, 4'd8, 4'h3, 32'h1234_5678);
    tick();
    idle();
    tick();
    n_checks++;
    if ({u1_a_valid, u1_b_valid, u1_a_data} !== {2'b10, 32'h0000_5678}) begin
      n_fail++; $display("FAIL rw_fwd_a_l1 got %b%b %h exp 10 00005678", u1_a_valid, u1_b_valid, u1_a_data);
    end
    tick();
    n_checks++;
    if ({u2_a_valid, u2_b_valid, u2_a_data} !== {2'b10, 32'h0000_5678}) begin
      n_fail++; $display("FAIL rw_fwd_a_l2 got %b%b %h exp 10 00005678", u2_a_valid, u2_b_valid, u2_a_data);
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] vals [3];
    int i1, i2;
    vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002; vals[2] = 32'h3333_0003;
    for (int i = 0; i < 3; i++) begin
      drive_a(0, 1, 4'(i + 1), 4'hf, vals[i]);
      tick();
    end
    for (int k = 1; k <= 6; k++) begin
      if (k <= 3) drive_a(1, 0, 4'(k), 4'hf, 32'h0);
      else idle();
      tick();
      i1 = k > 4 ? 2 : (k < 2 ? 0 : k - 2);
      i2 = k > 5 ? 2 : (k < 3 ? 0 : k - 3);
      n_checks++;
      if (u1_a_valid !== (k >= 2 && k <= 4) || (k >= 2 && u1_a_data !== vals[i1])) begin
        n_fail++; $display("FAIL b2b_l1 cycle %0d got %b %h exp %b %h", k, u1_a_valid, u1_a_data, k >= 2 && k <= 4, vals[i1]);
      end
      n_checks++;
      if (u2_a_valid !== (k >= 3 && k <= 5) || (k >= 3 && u2_a_data !== vals[i2])) begin
        n_fail++; $display("FAIL b2b_l2 cycle %0d got %b %h exp %b %h", k, u2_a_valid, u2_a_data, k >= 3 && k <= 5, vals[i2]);
      end
    end
  endtask
  task automatic test_reset_midflight();
    drive_a(1, 0, 4'd1, 4'hf, 32'h0);
    tick();
    idle();
    reset_n = 0;
    #1;
    n_checks++;
    if ({u1_a_valid, u2_a_valid, u1_a_wait, u2_a_wait, u1_a_data, u2_a_data} !== {4'b0011, 64'h0}) begin
      n_fail++; $display("FAIL midreset_async got %b%b%b%b %h %h exp 0011 0 0", u1_a_valid, u2_a_valid, u1_a_wait, u2_a_wait, u1_a_data, u2_a_data);
    end
    tick();
    reset_n = 1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      n_checks++;
      if ({u1_a_valid, u2_a_valid, u1_a_wait, u2_a_wait} !== {2'b00, {2{k < 16}}}) begin
        n_fail++; $display("FAIL midreset_clear cycle %0d got %b exp %b", k, {u1_a_valid, u2_a_valid, u1_a_wait, u2_a_wait}, {2'b00, {2{k < 16}}});
      end
    end
    drive_a(1, 0, 4'd1, 4'hf, 32'h0);
    tick();
    idle();
    tick();
    n_checks++;
    if ({u1_a_valid, u1_a_data} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL midreset_reread_l1 got %b %h exp 1 0", u1_a_valid, u1_a_data);
    end
    tick();
    n_checks++;
    if ({u2_a_valid, u2_a_data} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL midreset_reread_l2 got %b %h exp 1 0", u2_a_valid, u2_a_data);
    end
  endtask
  task automatic test_read_and_write();
    drive_a(1, 1, 4'd3, 4'hf, 32'h5);
    tick();
    idle();
    tick();
    n_checks++;
    if (u1_a_valid !== 1'b0) begin
      n_fail++; $display("FAIL rdwr_novalid_l1 got %b exp 0", u1_a_valid);
    end
    tick();
    n_checks++;
    if ({u1_a_valid, u2_a_valid} !== 2'b00) begin
      n_fail++; $display("FAIL rdwr_novalid_l2 got %b exp 00", {u1_a_valid, u2_a_valid});
    end
    drive_a(1, 0, 4'd3, 4'hf, 32'h0);
    tick();
    idle();
    tick();
    n_checks++;
    if ({u1_a_valid, u1_a_data} !== {1'b1, 32'h5}) begin
      n_fail++; $display("FAIL rdwr_reread_l1 got %b %h exp 1 00000005", u1_a_valid, u1_a_data);
    end
    tick();
    n_checks++;
    if ({u2_a_valid, u2_a_data} !== {1'b1, 32'h5}) begin
      n_fail++; $display("FAIL rdwr_reread_l2 got %b %h exp 1 00000005", u2_a_valid, u2_a_data);
    end
  endtask
  initial begin
    test_reset();
    test_clear_contents();
    test_write_collision();
    test_read_write_collision();
    test_back_to_back();
    test_reset_midflight();
    test_read_and_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
